// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: the opcode encoding, the per-entry
// record, and small opcode-classification helpers.
// Used by param_rob, rob_wb_arbiter and anything that issues to the ROB.
package rob_pkg;

  localparam int XLEN = 32;

  // Opcode encoding shared between decode, issue and the ROB.
  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_LUI   = 5'd10;
  localparam logic [4:0] OP_AUIPC = 5'd11;
  localparam logic [4:0] OP_JAL   = 5'd12;
  localparam logic [4:0] OP_JAL_C = 5'd13;
  localparam logic [4:0] OP_JALR  = 5'd14;
  localparam logic [4:0] OP_BEQ   = 5'd15;
  localparam logic [4:0] OP_BNE   = 5'd16;
  localparam logic [4:0] OP_BLT   = 5'd17;
  localparam logic [4:0] OP_BGE   = 5'd18;
  localparam logic [4:0] OP_BLTU  = 5'd19;
  localparam logic [4:0] OP_BGEU  = 5'd20;
  localparam logic [4:0] OP_LB    = 5'd21;
  localparam logic [4:0] OP_LH    = 5'd22;
  localparam logic [4:0] OP_LW    = 5'd23;
  localparam logic [4:0] OP_LBU   = 5'd24;
  localparam logic [4:0] OP_LHU   = 5'd25;
  localparam logic [4:0] OP_SB    = 5'd26;
  localparam logic [4:0] OP_SH    = 5'd27;
  localparam logic [4:0] OP_SW    = 5'd28;

  typedef struct packed {
    logic            busy;
    logic            ready;
    logic [4:0]      op;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] value;  // result; branch: bit 0 = taken; JALR: target
  } rob_entry_t;

  function automatic logic is_branch(input logic [4:0] op);
    return op inside {[OP_BEQ:OP_BGEU]};
  endfunction

  function automatic logic is_store(input logic [4:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  // Ops whose result is known from pc/imm alone skip the writeback path.
  function automatic logic ready_at_alloc(input logic [4:0] op);
    return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JAL_C};
  endfunction

  function automatic logic [XLEN-1:0] alloc_value(input logic [4:0]      op,
                                                  input logic [XLEN-1:0] pc,
                                                  input logic [XLEN-1:0] imm);
    case (op)
      OP_LUI:   return imm;
      OP_AUIPC: return pc + imm;
      OP_JAL:   return pc + XLEN'(4);
      OP_JAL_C: return pc + XLEN'(2);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/param_rob_if.sv
// Bus between the issue/execute side and the reorder buffer.
//   alloc_*        : issue handshake and allocated tag
//   wb_*           : NUM_WB packed writeback channels
//   q1_*/q2_*      : operand lookup by tag
//   commit_*, store_commit_*, redirect_* : registered retire outputs
//   count/empty/full : occupancy
// master = issuing core side, slave = the ROB.
interface param_rob_if #(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 2,
  parameter int TAG_W  = $clog2(DEPTH + 1)
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   alloc_valid;
  logic                   alloc_ready;
  logic [4:0]             alloc_op;
  logic [4:0]             alloc_rd;
  logic [31:0]            alloc_pc;
  logic [31:0]            alloc_imm;
  logic [TAG_W-1:0]       alloc_tag;

  logic [NUM_WB-1:0]      wb_valid;
  logic [NUM_WB*TAG_W-1:0] wb_tag;
  logic [NUM_WB*32-1:0]   wb_value;

  logic [TAG_W-1:0]       q1_tag;
  logic [TAG_W-1:0]       q2_tag;
  logic                   q1_ready;
  logic                   q2_ready;
  logic [31:0]            q1_value;
  logic [31:0]            q2_value;

  logic                   commit_valid;
  logic [4:0]             commit_rd;
  logic [TAG_W-1:0]       commit_tag;
  logic [31:0]            commit_value;
  logic                   store_commit_valid;
  logic [TAG_W-1:0]       store_commit_tag;
  logic                   redirect_valid;
  logic [31:0]            redirect_pc;

  logic [CNT_W-1:0]       count;
  logic                   empty;
  logic                   full;

  modport master (
    output alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_imm,
           wb_valid, wb_tag, wb_value, q1_tag, q2_tag,
    input  alloc_ready, alloc_tag, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_rd, commit_tag, commit_value,
           store_commit_valid, store_commit_tag, redirect_valid, redirect_pc,
           count, empty, full
  );

  modport slave (
    input  alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_imm,
           wb_valid, wb_tag, wb_value, q1_tag, q2_tag,
    output alloc_ready, alloc_tag, q1_ready, q2_ready, q1_value, q2_value,
           commit_valid, commit_rd, commit_tag, commit_value,
           store_commit_valid, store_commit_tag, redirect_valid, redirect_pc,
           count, empty, full
  );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Resolves NUM_WB writeback channels into one write enable and data word
// per ROB entry (entry index = tag - 1). Tag 0 and tags above DEPTH are
// dropped; when several channels hit one tag, the lowest channel wins.
// Ports: wb_valid/wb_tag/wb_value (packed channels) in; wr_en/wr_data out.
module rob_wb_arbiter
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 2,
  parameter int TAG_W  = $clog2(DEPTH + 1)
) (
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]      wb_tag,
  input  logic [NUM_WB*XLEN-1:0]       wb_value,
  output logic [DEPTH-1:0]             wr_en,
  output logic [DEPTH-1:0][XLEN-1:0]   wr_data
);
  localparam int IDX_W = $clog2(DEPTH);

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wr_en   = '0;
    wr_data = '0;
    // Highest channel first, so the lowest channel is written last and wins.
    for (int k = NUM_WB - 1; k >= 0; k--) begin
      if (wb_valid[k] && wb_tag[k*TAG_W +: TAG_W] != '0 &&
          wb_tag[k*TAG_W +: TAG_W] <= TAG_W'(DEPTH)) begin
        wr_en[IDX_W'(wb_tag[k*TAG_W +: TAG_W] - TAG_W'(1))]   = 1'b1;
        wr_data[IDX_W'(wb_tag[k*TAG_W +: TAG_W] - TAG_W'(1))] = wb_value[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/param_rob.sv
// Parameterised in-order-retire reorder buffer. Tags 1..DEPTH index a
// circular buffer (tag 0 = "no tag"). Entries are allocated at tail,
// completed by writeback, looked up by tag for operands, and retired one
// per cycle from head. Taken branches, JAL/JAL_C and JALR redirect the PC
// and flush every younger entry.
// Ports: clk, rst (synchronous, active-high), bus (param_rob_if.slave).
// Build option: PARAM_ROB_BYPASS_EN lets operand lookup see this cycle's
// writebacks; without it a result becomes visible one cycle after writeback.
module param_rob
  import rob_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 2,
  parameter int TAG_W  = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  param_rob_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  rob_entry_t       rob_q [DEPTH];
  logic [TAG_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;

  logic             commit_valid_q, store_commit_valid_q, redirect_valid_q;
  logic [4:0]       commit_rd_q;
  logic [TAG_W-1:0] commit_tag_q, store_commit_tag_q;
  logic [XLEN-1:0]  commit_value_q, redirect_pc_q;

  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == TAG_W'(DEPTH)) ? TAG_W'(1) : t + TAG_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  // Writeback resolution
  logic [DEPTH-1:0]           wr_en;
  logic [DEPTH-1:0][XLEN-1:0] wr_data;

  rob_wb_arbiter #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .TAG_W(TAG_W)) u_wb_arb (
    .wb_valid (bus.wb_valid),
    .wb_tag   (bus.wb_tag),
    .wb_value (bus.wb_value),
    .wr_en    (wr_en),
    .wr_data  (wr_data)
  );

  // Retire decode at head
  rob_entry_t      head_e;
  logic            retire, redirect, do_commit, do_store;
  logic [XLEN-1:0] retire_value, retire_target;

  always_comb begin
    head_e        = rob_q[idx_of(head_q)];
    retire        = head_e.busy && head_e.ready;
    redirect      = retire && ((head_e.op inside {OP_JAL, OP_JAL_C, OP_JALR}) ||
                               (is_branch(head_e.op) && head_e.value[0]));
    do_store      = retire && is_store(head_e.op);
    do_commit     = retire && !is_branch(head_e.op) && !is_store(head_e.op) &&
                    head_e.rd != 5'd0;
    // JALR stores its target in value; the link is rebuilt from pc.
    retire_value  = (head_e.op == OP_JALR) ? head_e.pc + XLEN'(4) : head_e.value;
    retire_target = (head_e.op == OP_JALR) ? head_e.value : head_e.pc + head_e.imm;
  end

  // Allocation: a flushing retire blocks issue for that cycle.
  logic full, alloc_fire;
  assign full            = (count_q == CNT_W'(DEPTH));
  assign bus.alloc_ready = !full && !redirect;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;
  assign bus.alloc_tag   = tail_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = (count_q == '0);

  // Operand lookup, two identical ports
  logic [TAG_W-1:0] q_tag   [2];
  logic             q_ready [2];
  logic [XLEN-1:0]  q_value [2];

  assign q_tag[0]     = bus.q1_tag;
  assign q_tag[1]     = bus.q2_tag;
  assign bus.q1_ready = q_ready[0];
  assign bus.q1_value = q_value[0];
  assign bus.q2_ready = q_ready[1];
  assign bus.q2_value = q_value[1];

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_ready[p] = 1'b0;
      q_value[p] = '0;
      if (q_tag[p] == '0) begin
        q_ready[p] = 1'b1;
      end else if (q_tag[p] <= TAG_W'(DEPTH)) begin
        if (rob_q[idx_of(q_tag[p])].busy && rob_q[idx_of(q_tag[p])].ready) begin
          q_ready[p] = 1'b1;
          q_value[p] = rob_q[idx_of(q_tag[p])].value;
        end
`ifdef PARAM_ROB_BYPASS_EN
        else if (rob_q[idx_of(q_tag[p])].busy && wr_en[idx_of(q_tag[p])]) begin
          q_ready[p] = 1'b1;
          q_value[p] = wr_data[idx_of(q_tag[p])];
        end
`endif
      end
    end
  end

  // State update
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= TAG_W'(1);
      tail_q  <= TAG_W'(1);
      count_q <= '0;
      // NOTE: the entry array is reset because busy/ready define occupancy;
      // stale busy bits would otherwise retire garbage after reset.
      for (int e = 0; e < DEPTH; e++) rob_q[e] <= '0;
      commit_valid_q       <= 1'b0;
      commit_rd_q          <= '0;
      commit_tag_q         <= '0;
      commit_value_q       <= '0;
      store_commit_valid_q <= 1'b0;
      store_commit_tag_q   <= '0;
      redirect_valid_q     <= 1'b0;
      redirect_pc_q        <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this
      // block sees the pre-edge state regardless of statement order.
      commit_valid_q       <= do_commit;
      store_commit_valid_q <= do_store;
      redirect_valid_q     <= redirect;
      if (retire) begin
        commit_rd_q        <= head_e.rd;
        commit_tag_q       <= head_q;
        commit_value_q     <= retire_value;
        store_commit_tag_q <= head_q;
        redirect_pc_q      <= retire_target;
      end

      if (redirect) begin
        // Everything younger than head is on the wrong path.
        for (int e = 0; e < DEPTH; e++) rob_q[e] <= '0;
        head_q  <= next_tag(head_q);
        tail_q  <= next_tag(head_q);
        count_q <= '0;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (wr_en[e] && rob_q[e].busy && !rob_q[e].ready) begin
            rob_q[e].ready <= 1'b1;
            rob_q[e].value <= wr_data[e];
          end
        end
        if (retire) begin
          rob_q[idx_of(head_q)].busy  <= 1'b0;
          rob_q[idx_of(head_q)].ready <= 1'b0;
          head_q <= next_tag(head_q);
        end
        if (alloc_fire) begin
          rob_q[idx_of(tail_q)] <= '{busy:  1'b1,
                                     ready: ready_at_alloc(bus.alloc_op),
                                     op:    bus.alloc_op,
                                     rd:    bus.alloc_rd,
                                     pc:    bus.alloc_pc,
                                     imm:   bus.alloc_imm,
                                     value: alloc_value(bus.alloc_op, bus.alloc_pc, bus.alloc_imm)};
          tail_q <= next_tag(tail_q);
        end
        count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(retire);
      end
    end
  end

  assign bus.commit_valid       = commit_valid_q;
  assign bus.commit_rd          = commit_rd_q;
  assign bus.commit_tag         = commit_tag_q;
  assign bus.commit_value       = commit_value_q;
  assign bus.store_commit_valid = store_commit_valid_q;
  assign bus.store_commit_tag   = store_commit_tag_q;
  assign bus.redirect_valid     = redirect_valid_q;
  assign bus.redirect_pc        = redirect_pc_q;

endmodule

// File: doc/param_rob.md
PARAM_ROB -- requirements
Module: param_rob

Interface
REQ-001 Parameter DEPTH, default 8, number of entries; power of two, 4..64.
REQ-002 Parameter NUM_WB, default 2, number of independent writeback channels.
REQ-003 Parameter TAG_W, default $clog2(DEPTH+1), tag width; tag 0 means "no tag", valid tags 1..DEPTH.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 alloc_valid / alloc_ready  in/out  1  issue handshake; transfer when both high.
REQ-007 alloc_op, alloc_rd  in  5  opcode (shared opcode encoding), destination register.
REQ-008 alloc_pc, alloc_imm  in  32  instruction PC, immediate.
REQ-009 alloc_tag  out  TAG_W  tag given to the current allocation, combinational from tail.
REQ-010 wb_valid  in  NUM_WB; wb_tag  in  NUM_WB*TAG_W; wb_value  in  NUM_WB*32  result writeback.
REQ-011 q1_tag, q2_tag  in  TAG_W; q1_ready, q2_ready  out  1; q1_value, q2_value  out  32  combinational operand lookup.
REQ-012 commit_valid  out  1; commit_rd  out  5; commit_tag  out  TAG_W; commit_value  out  32  registered retire.
REQ-013 store_commit_valid  out  1; store_commit_tag  out  TAG_W  store released to the load/store unit.
REQ-014 redirect_valid  out  1; redirect_pc  out  32  PC redirect plus flush pulse.
REQ-015 count  out  $clog2(DEPTH+1)  occupied entries; empty, full  out  1.

Function
REQ-016 Circular buffer with head/tail over tags 1..DEPTH; DEPTH wraps to 1; tag 0 never allocated.
REQ-017 alloc_ready = !full; full = (count == DEPTH); a commit in the same cycle does not raise alloc_ready.
REQ-018 LUI, AUIPC, JAL and JAL_C are ready at allocation with value imm, pc+imm, pc+4 and pc+2 respectively; all other ops are allocated not-ready.
REQ-019 Writeback on channel k to a busy, not-ready entry sets ready and stores wb_value; writebacks to idle tags are ignored; on equal tags the lowest k wins.
REQ-020 For branches, wb_value[0] = taken; for JALR, wb_value = target, and the link value pc+4 is kept separately.
REQ-021 Lookup: tag 0, or a busy ready entry, gives ready=1 with the stored value; otherwise ready=0 and value 0.
REQ-022 Retirement is in order, at most one per cycle, taken from head when the head is busy and ready; outputs are registered and appear the cycle after the retirement edge.
REQ-023 Non-branch retire: commit_valid=1 when rd!=0. Stores (SB/SH/SW) pulse store_commit_valid with their tag and do not write rd.
REQ-024 Retire of a taken branch sets redirect_pc=pc+imm. Retire of a JALR sets redirect_pc=target and commits the link value. Both pulse redirect_valid for one cycle.
REQ-025 On the retire edge that raises redirect_valid, all younger entries are cleared: head=tail=next tag, count=0. That flush overrides an allocation in the same cycle, and alloc_ready is 0 during that cycle.
REQ-026 A not-taken branch retires with commit_valid=0 and redirect_valid=0.
REQ-027 count += accepted alloc, -= retire; allocation and retire in the same cycle leave count unchanged.

Reset
REQ-028 While rst is high: head=tail=1, count=0, all entries idle and not-ready, and every output register is 0; alloc_tag=1, empty=1.
REQ-029 Reset asserted mid-operation drops all in-flight entries at the next edge; no retire or redirect is emitted that cycle.

Configuration
REQ-030 Macro PARAM_ROB_BYPASS_EN defined: the lookup also matches this cycle's wb_valid/wb_tag (lowest channel first) and returns ready=1 with wb_value. Undefined: the lookup sees only stored state, so a value is visible one cycle after writeback.

Structure
REQ-031 Opcode localparams and the entry struct (busy, ready, op, rd, pc, imm, value) live in shared package rob_pkg.
REQ-032 Sub-module rob_wb_arbiter resolves NUM_WB writebacks into per-entry write enables; lookup and retire logic stay in param_rob.

Verification
REQ-033 Allocate 8 ADDs with DEPTH=8 -> full=1, alloc_ready=0, count=8; tags 1..8, then wrap to 1 after a retire.
REQ-034 Write back ADD tag 3 with 0x55 while head is tag 1 -> no commit until tags 1 and 2 retire; tag 3 then commits 0x55 in order.
REQ-035 BEQ pc=0x100, imm=0x20, written back taken, plus 3 younger entries -> redirect_valid=1 with redirect_pc=0x120; count=0 the next cycle.
REQ-036 JAL pc=0x40, rd=1 -> retires without a writeback; commit_value=0x44, redirect_pc=0x40+imm.
REQ-037 Two channels write tag 2 in the same cycle with 0xA and 0xB -> stored value 0xA; with bypass, q1_tag=2 in the same cycle -> q1_ready=1, q1_value=0xA.
REQ-038 Assert rst with 5 entries busy -> next cycle count=0, empty=1, no commit_valid and no redirect_valid.
